mips_fetch_decode: RTL and testbench

Front end of the pipelined MIPS core. It owns the program counter and reads 32-bit words from the 1024-entry instruction memory that the bench fills. Each word is classified as R-, I- or J-type, split into fields and presented to the execute stage through an IF/ID pipeline register. Stall, flush and redirect inputs are provided for hazard and branch control.

---
 rtl/instruction_pkg.sv | 63 ++++++
 rtl/mips_fetch_decode_if.sv | 43 ++++
 rtl/mips_instr_decode.sv | 44 ++++
 rtl/mips_fetch_decode.sv | 72 +++++++
 tb/tb_mips_fetch_decode.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_pkg.sv
// instruction_pkg
// Shared MIPS instruction vocabulary for the fetch/decode front end and for
// anything that has to build instruction words (generators, models).
// Contents: the instruction class enum, the opcodes that select the class,
// field bit positions, a classifier and R/I/J word encoders.
package instruction_pkg;

    typedef enum logic [1:0] {
        NONE_type = 2'd0,
        R_type    = 2'd1,
        I_type    = 2'd2,
        J_type    = 2'd3
    } types;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic types decode_type(input logic [5:0] opcode);
        types t;
        if (opcode == OP_RTYPE) begin
            t = R_type;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            t = J_type;
        end else begin
            t = I_type;
        end
        return t;
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/mips_fetch_decode_if.sv
// mips_fetch_decode_if
// Bundles the instruction-memory port, the hazard/branch controls and the
// decoded IF/ID outputs of the fetch/decode front end.
//   master : the front end (drives imem_addr and id_*, receives imem_data,
//            stall, redirect, redirect_pc)
//   slave  : the surrounding pipeline / memory (opposite directions)
interface mips_fetch_decode_if #(
    parameter int AW = 10
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;

    logic          id_valid;
    logic [31:0]   id_pc_plus4;
    logic [1:0]    id_type;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;
    logic [4:0]    id_shamt;
    logic [5:0]    id_funct;
    logic [31:0]   id_imm_sext;
    logic [31:0]   id_imm_zext;
    logic [31:0]   id_jump_target;

    modport master (
        output imem_addr,
        input  imem_data, stall, redirect, redirect_pc,
        output id_valid, id_pc_plus4, id_type, id_opcode, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_imm_sext, id_imm_zext, id_jump_target
    );

    modport slave (
        input  imem_addr,
        output imem_data, stall, redirect, redirect_pc,
        input  id_valid, id_pc_plus4, id_type, id_opcode, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_imm_sext, id_imm_zext, id_jump_target
    );

endinterface

// File: rtl/mips_instr_decode.sv
// mips_instr_decode
// Purely combinational field splitter and R/I/J classifier for the word held
// in the IF/ID register.
//   word       in  32 : held instruction word
//   valid      in   1 : held word is a real instruction (not a bubble)
//   pc_hi      in   4 : bits [31:28] of the held PC+4, region for jumps
//   id_type    out  2 : class, 0 when not valid
//   id_*       out    : raw fields, immediates and jump target
module mips_instr_decode
    import instruction_pkg::*;
(
    input  logic [31:0] word,
    input  logic        valid,
    input  logic [3:0]  pc_hi,
    output logic [1:0]  id_type,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [31:0] id_imm_sext,
    output logic [31:0] id_imm_zext,
    output logic [31:0] id_jump_target
);

    logic [15:0] imm;

    assign imm       = word[IMM_MSB:IMM_LSB];
    assign id_opcode = word[OPCODE_MSB:OPCODE_LSB];
    assign id_rs     = word[RS_MSB:RS_LSB];
    assign id_rt     = word[RT_MSB:RT_LSB];
    assign id_rd     = word[RD_MSB:RD_LSB];
    assign id_shamt  = word[SHAMT_MSB:SHAMT_LSB];
    assign id_funct  = word[FUNCT_MSB:FUNCT_LSB];

    assign id_imm_sext    = {{16{imm[15]}}, imm};
    assign id_imm_zext    = {16'h0000, imm};
    assign id_jump_target = {pc_hi, word[TARGET_MSB:TARGET_LSB], 2'b00};

    // Fields always track the held word; only the class is gated by valid.
    assign id_type = valid ? decode_type(id_opcode) : NONE_type;

endmodule

// File: rtl/mips_fetch_decode.sv
// mips_fetch_decode
// Front end of the pipelined MIPS core: program counter, instruction fetch
// and the IF/ID pipeline register, with decode done by mips_instr_decode.
//   clk   in  1 : clock, rising edge
//   rst   in  1 : synchronous active-high reset
//   bus   master modport of mips_fetch_decode_if
//         imem_addr out 10 = pc[11:2]; imem_data in 32 (combinational read)
//         stall, redirect, redirect_pc in; id_* decoded outputs
// Priority on each edge: rst > redirect > stall > advance.
module mips_fetch_decode
    import instruction_pkg::*;
#(
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    mips_fetch_decode_if.master bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ifid_word;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    assign pc_plus4      = pc + 32'd4;
    // Only the word-index bits address memory, so the index wraps naturally.
    assign bus.imem_addr = pc[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            ifid_word     <= 32'h0;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (bus.redirect) begin
            // Taken even when stalled; the word fetched this cycle is from the
            // wrong path and becomes a bubble.
            pc         <= bus.redirect_pc & 32'hFFFF_FFFC;
            ifid_word  <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (!bus.stall) begin
            pc            <= pc_plus4;
            ifid_word     <= bus.imem_data;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

    assign bus.id_valid    = ifid_valid;
    assign bus.id_pc_plus4 = ifid_pc_plus4;

    mips_instr_decode u_decode (
        .word           (ifid_word),
        .valid          (ifid_valid),
        .pc_hi          (ifid_pc_plus4[31:28]),
        .id_type        (bus.id_type),
        .id_opcode      (bus.id_opcode),
        .id_rs          (bus.id_rs),
        .id_rt          (bus.id_rt),
        .id_rd          (bus.id_rd),
        .id_shamt       (bus.id_shamt),
        .id_funct       (bus.id_funct),
        .id_imm_sext    (bus.id_imm_sext),
        .id_imm_zext    (bus.id_imm_zext),
        .id_jump_target (bus.id_jump_target)
    );

endmodule

// File: tb/tb_mips_fetch_decode.sv
module tb_mips_fetch_decode;
    import instruction_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    mips_fetch_decode_if #(.AW(10)) bus ();

    mips_fetch_decode #(.IMEM_DEPTH(1024), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] imem [1024];
    int          kind [1024];

    assign bus.imem_data = imem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: what the front end should hold after each edge
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic [31:0] m_pcp4;
    logic        m_valid;
    int          m_kind;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gen_word(output int k);
        logic [5:0] op;
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0) begin
            k = 1;
            return enc_r(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
        end else if (sel == 1) begin
            k = 2;
            op = 6'($urandom_range(1, 63));
            if (op == 6'd2 || op == 6'd3) op = 6'd8;
            return enc_i(op, 5'($urandom), 5'($urandom), 16'($urandom));
        end else begin
            k = 3;
            op = ($urandom_range(0, 1) == 0) ? OP_J : OP_JAL;
            return enc_j(op, 26'($urandom));
        end
    endfunction

    task automatic model_edge(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        int idx;
        if (r) begin
            m_pc = RESET_PC; m_word = 0; m_pcp4 = 0; m_valid = 0; m_kind = 0;
        end else if (rd) begin
            m_pc = rpc - (rpc % 4); m_word = 0; m_valid = 0; m_kind = 0;
        end else if (!st) begin
            idx = int'((m_pc / 4) % 1024);
            m_word = imem[idx]; m_kind = kind[idx];
            m_pcp4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all();
        logic [31:0] w;
        logic [31:0] sext;
        w = m_word;
        sext = (w & 32'h8000) != 0 ? (32'hFFFF_0000 | (w & 32'hFFFF)) : (w & 32'hFFFF);
        chk("imem_addr", 32'(bus.imem_addr), (m_pc / 4) % 1024);
        chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
        chk("id_type", 32'(bus.id_type), m_valid ? 32'(m_kind) : 32'd0);
        chk("id_opcode", 32'(bus.id_opcode), w >> 26);
        chk("id_rs", 32'(bus.id_rs), (w >> 21) & 32'h1F);
        chk("id_rt", 32'(bus.id_rt), (w >> 16) & 32'h1F);
        chk("id_rd", 32'(bus.id_rd), (w >> 11) & 32'h1F);
        chk("id_shamt", 32'(bus.id_shamt), (w >> 6) & 32'h1F);
        chk("id_funct", 32'(bus.id_funct), w & 32'h3F);
        chk("id_imm_sext", bus.id_imm_sext, sext);
        chk("id_imm_zext", bus.id_imm_zext, w & 32'hFFFF);
        if (m_valid) begin
            chk("id_pc_plus4", bus.id_pc_plus4, m_pcp4);
            chk("id_jump_target", bus.id_jump_target,
                (m_pcp4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4));
        end
    endtask

    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        rst             = r;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, st, rd, rpc);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        m_pc = RESET_PC; m_word = 0; m_pcp4 = 0; m_valid = 0; m_kind = 0;

        for (int i = 0; i < 1024; i++) begin
            int k;
            imem[i] = gen_word(k);
            kind[i] = k;
        end
        imem[20] = 32'h012A_4020; kind[20] = 1;
        imem[21] = 32'h2128_FFFF; kind[21] = 2;
        imem[22] = 32'h0C00_0010; kind[22] = 3;

        // reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_valid", 32'(bus.id_valid), 32'd0);
        chk("reset_type", 32'(bus.id_type), 32'd0);
        chk("reset_addr", 32'(bus.imem_addr), 32'd0);

        // sequential fetch
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0);
            chk("seq_pc_plus4", bus.id_pc_plus4, 32'(4 * (i + 1)));
        end

        // stall while word 5 is decoded
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("pre_stall_pc_plus4", bus.id_pc_plus4, 32'd24);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_hold_pc_plus4", bus.id_pc_plus4, 32'd24);
            chk("stall_hold_word", {26'h0, bus.id_funct}, imem[5] & 32'h3F);
        end
        step(0, 0, 0, 0);
        chk("post_stall_pc_plus4", bus.id_pc_plus4, 32'd28);

        // simultaneous stall + redirect
        step(0, 1, 1, 32'h0000_0100);
        chk("bubble_valid", 32'(bus.id_valid), 32'd0);
        chk("bubble_type", 32'(bus.id_type), 32'd0);
        step(0, 0, 0, 0);
        chk("redir_pc_plus4", bus.id_pc_plus4, 32'h104);
        chk("redir_imm", bus.id_imm_zext, imem[64] & 32'hFFFF);

        // directed decode words (redirect_pc low bits are ignored)
        step(0, 0, 1, 32'h0000_0053);
        step(0, 0, 0, 0);
        chk("add_type", 32'(bus.id_type), 32'd1);
        chk("add_rs", 32'(bus.id_rs), 32'd9);
        chk("add_rt", 32'(bus.id_rt), 32'd10);
        chk("add_rd", 32'(bus.id_rd), 32'd8);
        chk("add_funct", 32'(bus.id_funct), 32'h20);
        step(0, 0, 0, 0);
        chk("addi_type", 32'(bus.id_type), 32'd2);
        chk("addi_sext", bus.id_imm_sext, 32'hFFFF_FFFF);
        chk("addi_zext", bus.id_imm_zext, 32'h0000_FFFF);
        step(0, 0, 0, 0);
        chk("jal_type", 32'(bus.id_type), 32'd3);
        chk("jal_target", bus.id_jump_target, 32'h0000_0040);

        // wrap of the memory index
        step(0, 0, 1, 32'h0000_0FFC);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd1023);
        step(0, 0, 0, 0);
        chk("wrap_pc_plus4", bus.id_pc_plus4, 32'h1000);
        chk("wrap_next_addr", 32'(bus.imem_addr), 32'd0);
        step(0, 0, 0, 0);
        chk("wrap_idx0_pc_plus4", bus.id_pc_plus4, 32'h1004);

        // randomized mix of advance / stall / redirect / reset
        for (int i = 0; i < 400; i++) begin
            int p;
            bit r, st, rd;
            p  = $urandom_range(0, 99);
            r  = (p < 2);
            rd = (p >= 2 && p < 12);
            st = (p >= 8 && p < 30);
            step(r, st, rd, $urandom);
        end

        // reset mid-stream during stall + redirect
        step(0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0200);
        chk("midrst_valid", 32'(bus.id_valid), 32'd0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'(RESET_PC[11:2]));
        step(0, 0, 0, 0);
        chk("midrst_first_pc_plus4", bus.id_pc_plus4, RESET_PC + 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
